sram_dp_param: RTL and testbench
================================

SRAM_DP_PARAM -- requirements
Module: sram_dp_param

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits; legal values are multiples of 8, from 8 to 64.
REQ-002 SHALL have parameter ADDR_WIDTH, default 9, address width; DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL derive the local value MASK_WIDTH = DATA_WIDTH/8, one mask bit per byte.
REQ-004 clk0  input  1  single clock; all state changes on its rising edge.
REQ-005 rst0  input  1  reset, synchronous, active-high.
REQ-006 csb0  input  1  port 0 chip select, active low.
REQ-007 web0  input  1  port 0 write enable, active low (1 = read).
REQ-008 wmask0  input  MASK_WIDTH  port 0 byte write mask, bit i enables byte i.
REQ-009 addr0  input  ADDR_WIDTH  port 0 address.
REQ-010 din0  input  DATA_WIDTH  port 0 write data.
REQ-011 dout0  output  DATA_WIDTH  port 0 read data.
REQ-012 dvalid0  output  1  dout0 carries fresh read data this cycle.
REQ-013 csb1  input  1  port 1 (read-only) chip select, active low.
REQ-014 addr1  input  ADDR_WIDTH  port 1 address.
REQ-015 dout1  output  DATA_WIDTH  port 1 read data.
REQ-016 dvalid1  output  1  dout1 carries fresh read data this cycle.
REQ-017 ready  output  1  initialisation complete; requests are accepted.

Function
REQ-018 SHALL contain a behavioural array of DEPTH x DATA_WIDTH bits.
REQ-019 SHALL implement a two-state FSM: INIT -> READY.
- INIT: internal counter writes zero to word 0 .. DEPTH-1, one word per cycle.
- Transition to READY occurs on the cycle after word DEPTH-1 is written.
REQ-020 ready SHALL be 0 in INIT and 1 in READY; it rises exactly DEPTH cycles after rst0 is deasserted.
REQ-021 In INIT, csb0 and csb1 SHALL be ignored: no array write, dvalid0 = dvalid1 = 0.
REQ-022 Port 0 write: when ready=1, csb0=0 and web0=0, byte i of word addr0 SHALL take din0 byte i where wmask0[i]=1; other bytes are unchanged.
REQ-023 A write with wmask0 all zero SHALL leave the array unchanged.
REQ-024 Port 0 read: when ready=1, csb0=0 and web0=1, dout0 SHALL equal word addr0 on the next cycle, with dvalid0=1 for exactly that cycle.
REQ-025 Port 1 read: when ready=1 and csb1=0, dout1 SHALL equal word addr1 on the next cycle, with dvalid1=1 for exactly that cycle.
REQ-026 dout0 and dout1 SHALL hold their last value when no read completes; a port 0 write SHALL NOT update dout0.
REQ-027 Both ports SHALL operate independently in the same cycle; reads to the same address, or to different addresses, SHALL both complete with 1-cycle latency.
REQ-028 Collision (port 0 write and port 1 read to the same address in the same cycle): dout1 SHALL follow REQ-033/REQ-034.
REQ-029 Address wrap: no address is out of range; address DEPTH-1 SHALL be fully usable.

Reset
REQ-030 rst0=1 SHALL force INIT, clear the init counter to 0, and set dout0=0, dout1=0, dvalid0=0, dvalid1=0, ready=0 on the next edge.
REQ-031 rst0 asserted mid-INIT or mid-READY SHALL restart the zero sweep at word 0 and discard any in-flight read.
REQ-032 While rst0=1, the array SHALL NOT be written.

Configuration
REQ-033 With macro SRAM_DP_FWD_EN defined, a collision read SHALL return the merged new word: masked bytes from din0, all other bytes from the old word.
REQ-034 Without SRAM_DP_FWD_EN, a collision read SHALL return the old word, unaffected by the same-cycle write.

Verification
REQ-035 Bench SHALL cover these directed scenarios:
- Reset, then DEPTH=512: ready=0 for 512 cycles, then 1; reading any address returns 0x00000000 with dvalid=1 one cycle later.
- Write 0xDEADBEEF to addr 5 with wmask0=4'b1111, then wmask0=4'b0101 with din0=0x11223344: port 1 read of addr 5 returns 0xDE22BE44.
- Collision on addr 7 (old value 0xAAAAAAAA; write 0x55555555 with mask 4'b0011): with the macro, dout1=0xAAAA5555; without it, dout1=0xAAAAAAAA.
- Simultaneous reads: port 0 reads addr 0 and port 1 reads addr 511 in the same cycle; both values are correct and dvalid0=dvalid1=1 on the same cycle.
- Requests issued during INIT: no write takes effect and dvalid stays 0; a later read shows 0.
- rst0 pulsed mid-READY after writes: ready drops, DEPTH-cycle sweep repeats, and previously written words read 0.
- Parameter sweep DATA_WIDTH=16, ADDR_WIDTH=4: ready rises after 16 cycles, and masked writes behave per REQ-022.

Source files
------------

// File: rtl/sram_dp_param.sv
// sram_dp_param: one read/write port plus one read-only port over a byte-maskable array, zeroed by a sweep after reset.
// Optional macro SRAM_DP_FWD_EN: a port 1 read colliding with a port 0 write returns the merged new word.
module sram_dp_param #(
    parameter  int DATA_WIDTH = 32,
    parameter  int ADDR_WIDTH = 9,
    localparam int MASK_WIDTH = DATA_WIDTH / 8
) (
    input  logic                  clk0,
    input  logic                  rst0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [MASK_WIDTH-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dvalid0,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dvalid1,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_t;

    state_t                  state;
    state_t                  state_next;
    logic                    init_wr;
    logic [ADDR_WIDTH-1:0]   init_cnt;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic                    rd0;
    logic                    wr0;
    logic                    rd1;
    logic [DATA_WIDTH-1:0]   wr_word;
    logic [DATA_WIDTH-1:0]   rd1_word;

    always_ff @(posedge clk0) begin
        if (rst0) begin
            state <= ST_INIT;
        end else begin
            state <= state_next;
        end
    end

    // The sweep ends on the edge that clears the last word.
    always_comb begin
        state_next = state;
        case (state)
            ST_INIT:  if (&init_cnt) state_next = ST_READY;
            ST_READY: state_next = ST_READY;
            default:  state_next = ST_INIT;
        endcase
    end

    always_comb begin
        ready   = (state == ST_READY);
        init_wr = (state == ST_INIT);
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            init_cnt <= '0;
        end else if (init_wr) begin
            init_cnt <= init_cnt + 1'b1;
        end
    end

    assign rd0 = ready && !csb0 && web0;
    assign wr0 = ready && !csb0 && !web0;
    assign rd1 = ready && !csb1;

    always_comb begin
        wr_word = mem[addr0];
        for (int i = 0; i < MASK_WIDTH; i++) begin
            if (wmask0[i]) wr_word[i*8 +: 8] = din0[i*8 +: 8];
        end
    end

`ifdef SRAM_DP_FWD_EN
    assign rd1_word = (wr0 && (addr0 == addr1)) ? wr_word : mem[addr1];
`else
    assign rd1_word = mem[addr1];
`endif

    always_ff @(posedge clk0) begin
        if (!rst0) begin
            if (init_wr) begin
                mem[init_cnt] <= '0;
            end else if (wr0) begin
                mem[addr0] <= wr_word;
            end
        end
    end

    always_ff @(posedge clk0) begin
        if (rst0) begin
            dout0   <= '0;
            dvalid0 <= 1'b0;
            dout1   <= '0;
            dvalid1 <= 1'b0;
        end else begin
            dvalid0 <= rd0;
            dvalid1 <= rd1;
            if (rd0) dout0 <= mem[addr0];
            if (rd1) dout1 <= rd1_word;
        end
    end

endmodule

// File: tb/tb_sram_dp_param.sv
// tb_sram_dp_param: randomized and directed checks of sram_dp_param (32x512 and 16x16 builds) against an array model.
module tb_sram_dp_param;

    localparam int DW = 32, AW = 9, DEPTH = 512, MW = 4;
    localparam int SDW = 16, SAW = 4, SDEPTH = 16, SMW = 2;

`ifdef SRAM_DP_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst0, csb0, web0, csb1;
    logic [MW-1:0] wmask0;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] din0, dout0, dout1;
    logic          dvalid0, dvalid1, ready;

    logic           s_rst0, s_csb0, s_web0, s_csb1;
    logic [SMW-1:0] s_wmask0;
    logic [SAW-1:0] s_addr0, s_addr1;
    logic [SDW-1:0] s_din0, s_dout0, s_dout1;
    logic           s_dvalid0, s_dvalid1, s_ready;

    sram_dp_param #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) u_dut (
        .clk0(clk), .rst0(rst0), .csb0(csb0), .web0(web0), .wmask0(wmask0),
        .addr0(addr0), .din0(din0), .dout0(dout0), .dvalid0(dvalid0),
        .csb1(csb1), .addr1(addr1), .dout1(dout1), .dvalid1(dvalid1), .ready(ready)
    );

    sram_dp_param #(.DATA_WIDTH(SDW), .ADDR_WIDTH(SAW)) u_small (
        .clk0(clk), .rst0(s_rst0), .csb0(s_csb0), .web0(s_web0), .wmask0(s_wmask0),
        .addr0(s_addr0), .din0(s_din0), .dout0(s_dout0), .dvalid0(s_dvalid0),
        .csb1(s_csb1), .addr1(s_addr1), .dout1(s_dout1), .dvalid1(s_dvalid1), .ready(s_ready)
    );

    int passed = 0;
    int total  = 0;

    // Reference state: memory contents, cycles left in the zero sweep, expected output registers.
    logic [DW-1:0]  m_mem [DEPTH];
    int             m_init;
    logic [DW-1:0]  m_dout0, m_dout1;
    logic           m_dv0, m_dv1;

    logic [SDW-1:0] sm_mem [SDEPTH];
    int             sm_init;
    logic [SDW-1:0] sm_dout0, sm_dout1;
    logic           sm_dv0, sm_dv1;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) passed++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] m);
        logic [63:0] r;
        r = old;
        for (int i = 0; i < 8; i++) begin
            if (m[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    task automatic applyStimulus(input logic r, input logic c0, input logic w0, input logic [MW-1:0] m,
                                 input int a0, input logic [DW-1:0] d, input logic c1, input int a1);
        logic [DW-1:0] nxt;
        rst0 = r; csb0 = c0; web0 = w0; wmask0 = m; addr0 = a0[AW-1:0]; din0 = d; csb1 = c1; addr1 = a1[AW-1:0];
        if (r) begin
            m_init = DEPTH; m_dout0 = '0; m_dout1 = '0; m_dv0 = 1'b0; m_dv1 = 1'b0;
            for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
        end else if (m_init > 0) begin
            m_init--; m_dv0 = 1'b0; m_dv1 = 1'b0;
        end else begin
            nxt   = merge(64'(m_mem[a0]), 64'(d), 8'(m));
            m_dv0 = !c0 && w0;
            m_dv1 = !c1;
            if (m_dv0) m_dout0 = m_mem[a0];
            if (m_dv1) m_dout1 = (FWD && !c0 && !w0 && a0 == a1) ? nxt : m_mem[a1];
            if (!c0 && !w0) m_mem[a0] = nxt;
        end
        @(posedge clk); #1;
        checkOutput("ready",   64'(ready),   64'(m_init == 0));
        checkOutput("dvalid0", 64'(dvalid0), 64'(m_dv0));
        checkOutput("dvalid1", 64'(dvalid1), 64'(m_dv1));
        checkOutput("dout0",   64'(dout0),   64'(m_dout0));
        checkOutput("dout1",   64'(dout1),   64'(m_dout1));
    endtask

    task automatic applySmall(input logic r, input logic c0, input logic w0, input logic [SMW-1:0] m,
                              input int a0, input logic [SDW-1:0] d, input logic c1, input int a1);
        logic [SDW-1:0] nxt;
        s_rst0 = r; s_csb0 = c0; s_web0 = w0; s_wmask0 = m; s_addr0 = a0[SAW-1:0]; s_din0 = d;
        s_csb1 = c1; s_addr1 = a1[SAW-1:0];
        if (r) begin
            sm_init = SDEPTH; sm_dout0 = '0; sm_dout1 = '0; sm_dv0 = 1'b0; sm_dv1 = 1'b0;
            for (int i = 0; i < SDEPTH; i++) sm_mem[i] = '0;
        end else if (sm_init > 0) begin
            sm_init--; sm_dv0 = 1'b0; sm_dv1 = 1'b0;
        end else begin
            nxt    = merge(64'(sm_mem[a0]), 64'(d), 8'(m));
            sm_dv0 = !c0 && w0;
            sm_dv1 = !c1;
            if (sm_dv0) sm_dout0 = sm_mem[a0];
            if (sm_dv1) sm_dout1 = (FWD && !c0 && !w0 && a0 == a1) ? nxt : sm_mem[a1];
            if (!c0 && !w0) sm_mem[a0] = nxt;
        end
        @(posedge clk); #1;
        checkOutput("s_ready",   64'(s_ready),   64'(sm_init == 0));
        checkOutput("s_dvalid0", 64'(s_dvalid0), 64'(sm_dv0));
        checkOutput("s_dvalid1", 64'(s_dvalid1), 64'(sm_dv1));
        checkOutput("s_dout0",   64'(s_dout0),   64'(sm_dout0));
        checkOutput("s_dout1",   64'(s_dout1),   64'(sm_dout1));
    endtask

    function automatic int pick_addr();
        return ($urandom_range(0, 7) == 0) ? DEPTH - 1 : int'($urandom_range(0, 15));
    endfunction

    initial begin
        s_rst0 = 1'b1; s_csb0 = 1'b1; s_web0 = 1'b1; s_wmask0 = '0;
        s_addr0 = '0; s_addr1 = '0; s_din0 = '0; s_csb1 = 1'b1;

        applyStimulus(1, 1, 1, '0, 0, '0, 1, 0);
        applyStimulus(1, 1, 1, '0, 0, '0, 1, 0);

        // Requests during the sweep must be ignored; ready is checked every cycle.
        for (int i = 0; i < DEPTH; i++)
            applyStimulus(0, 0, i[0], 4'hF, 3, $urandom, 0, int'($urandom_range(0, DEPTH - 1)));
        checkOutput("ready_after_sweep", 64'(ready), 64'd1);

        applyStimulus(0, 0, 1, '0, 3, '0, 0, 200);
        checkOutput("init_write_ignored", 64'(dout0), 64'd0);
        checkOutput("init_read_dv1", 64'(dvalid1), 64'd1);

        applyStimulus(0, 0, 0, 4'hF, 5, 32'hDEADBEEF, 1, 0);
        applyStimulus(0, 0, 0, 4'h5, 5, 32'h11223344, 1, 0);
        applyStimulus(0, 1, 1, '0, 0, '0, 0, 5);
        checkOutput("mask_merge", 64'(dout1), 64'h DE22BE44);

        applyStimulus(0, 0, 0, 4'h0, 5, 32'hFFFFFFFF, 1, 0);
        applyStimulus(0, 0, 1, '0, 5, '0, 1, 0);
        checkOutput("zero_mask", 64'(dout0), 64'h DE22BE44);
        applyStimulus(0, 1, 1, '0, 0, '0, 1, 0);
        checkOutput("dv0_one_cycle", 64'(dvalid0), 64'd0);

        applyStimulus(0, 0, 0, 4'hF, 7, 32'hAAAAAAAA, 1, 0);
        applyStimulus(0, 0, 0, 4'h3, 7, 32'h55555555, 0, 7);
        checkOutput("collision", 64'(dout1), FWD ? 64'h AAAA5555 : 64'h AAAAAAAA);
        applyStimulus(0, 0, 1, '0, 7, '0, 1, 0);
        checkOutput("after_collision", 64'(dout0), 64'h AAAA5555);
        applyStimulus(0, 0, 0, 4'hF, 9, 32'h12345678, 1, 0);
        checkOutput("write_keeps_dout0", 64'(dout0), 64'h AAAA5555);

        applyStimulus(0, 0, 0, 4'hF, DEPTH - 1, 32'hCAFEF00D, 1, 0);
        applyStimulus(0, 0, 1, '0, 0, '0, 0, DEPTH - 1);
        checkOutput("sim_dv0", 64'(dvalid0), 64'd1);
        checkOutput("sim_dv1", 64'(dvalid1), 64'd1);
        checkOutput("sim_dout0", 64'(dout0), 64'd0);
        checkOutput("sim_dout1", 64'(dout1), 64'h CAFEF00D);
        applyStimulus(0, 0, 1, '0, 5, '0, 0, 5);

        for (int i = 0; i < 400; i++)
            applyStimulus(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 4'($urandom),
                          pick_addr(), $urandom, $urandom_range(0, 2) == 0, pick_addr());

        // Reset mid-READY with a read in flight, then again mid-sweep.
        applyStimulus(0, 0, 1, '0, 5, '0, 0, 7);
        applyStimulus(1, 0, 1, '0, 5, '0, 0, 7);
        checkOutput("reset_ready_low", 64'(ready), 64'd0);
        checkOutput("reset_dout1", 64'(dout1), 64'd0);
        for (int i = 0; i < 100; i++) applyStimulus(0, 1, 1, '0, 0, '0, 1, 0);
        applyStimulus(1, 1, 1, '0, 0, '0, 1, 0);
        for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 4'hF, 5, $urandom, 1, 0);
        applyStimulus(0, 0, 1, '0, 7, '0, 0, DEPTH - 1);
        checkOutput("sweep_cleared0", 64'(dout0), 64'd0);
        checkOutput("sweep_cleared1", 64'(dout1), 64'd0);
        applyStimulus(0, 0, 1, '0, 5, '0, 0, 9);
        checkOutput("sweep_cleared5", 64'(dout0), 64'd0);

        applySmall(1, 1, 1, '0, 0, '0, 1, 0);
        for (int i = 0; i < SDEPTH; i++) applySmall(0, 0, 0, 2'b11, 2, 16'hFFFF, 0, 2);
        checkOutput("small_ready", 64'(s_ready), 64'd1);
        applySmall(0, 0, 0, 2'b11, 15, 16'hBEEF, 1, 0);
        applySmall(0, 0, 0, 2'b10, 15, 16'h1234, 1, 0);
        applySmall(0, 0, 1, '0, 15, '0, 0, 2);
        checkOutput("small_merge", 64'(s_dout0), 64'h 12EF);
        checkOutput("small_untouched", 64'(s_dout1), 64'd0);
        for (int i = 0; i < 80; i++)
            applySmall(0, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 2'($urandom),
                       int'($urandom_range(0, SDEPTH - 1)), 16'($urandom),
                       $urandom_range(0, 2) == 0, int'($urandom_range(0, SDEPTH - 1)));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
